hls_axis_stall_detector: RTL and testbench
==========================================

Name: hls_axis_stall_detector

Overview:
- Producer side of the HLS deadlock-monitor block signals: watches the NUM_CH AXI-Stream ports of an HLS kernel instance and generates the per-channel axis_block_sigs consumed by the deadlock monitor.
- A channel is flagged when it sits in a stalled handshake state for THRESHOLD consecutive cycles.
- Also latches a sticky trip record: first channel, stall kind and age since trip, for readout via debug/AXI-Lite status.

Parameters:
- NUM_CH, 4, number of monitored AXIS channels (1..32).
- CNT_W, 16, width of per-channel stall counters and trip_age.
- THRESHOLD, 1024, consecutive stall cycles before a channel is flagged; legal range 1..2^CNT_W-1.

Ports:
- clock  in  1  clock, all logic rising-edge.
- reset  in  1  reset, synchronous, active-high.
- tvalid  in  NUM_CH  per-channel AXIS TVALID (sampled only, not driven).
- tready  in  NUM_CH  per-channel AXIS TREADY (sampled only).
- inst_idle  in  1  kernel instance idle indicator.
- clear  in  1  single-cycle pulse; clears the sticky trip record.
- axis_block_sigs  out  NUM_CH  per-channel stall flag, registered.
- stall_sticky  out  1  high once any channel has tripped, until clear.
- first_ch  out  CH_W  index of the tripping channel; CH_W = max(1, clog2(NUM_CH)).
- first_kind  out  1  stall kind at trip: 1 = backpressure (valid & !ready), 0 = starvation (ready & !valid).
- trip_age  out  CNT_W  cycles elapsed since trip; saturating.

Behaviour:
- Reset: all stall counters, axis_block_sigs, stall_sticky, first_ch, first_kind and trip_age go to 0. FSM enters WATCH.

Per-channel stall counter (cnt[i]):
- stall[i] = tvalid[i] XOR tready[i].
- Handshake (valid & ready): cnt <= 0.
- Both low with inst_idle=1: cnt <= 0.
- Both low with inst_idle=0: cnt holds.
- stall[i]=1: cnt increments, saturating at 2^CNT_W-1; no wrap.
- kind[i] is registered each stalled cycle as tvalid[i].
- axis_block_sigs[i] is registered as (next cnt[i] >= THRESHOLD).
- Resulting timing: with stall first sampled at edge k, the flag is visible after edge k+THRESHOLD-1. With THRESHOLD=1, the flag rises on the same edge the stall is first sampled.
- Flag deassertion: the flag drops on the edge that samples the handshake or idle condition, one-cycle latency.
- Starvation-to-backpressure transitions with no intervening handshake continue counting.

Trip FSM:
- WATCH: if any axis_block_sigs bit is high and clear=0:
  - first_ch <= lowest set index;
  - first_kind <= kind of that channel;
  - stall_sticky <= 1;
  - trip_age <= 0;
  - go to TRIPPED.
- TRIPPED:
  - first_ch and first_kind frozen; later trips on other channels are ignored.
  - trip_age increments each cycle, saturating.
  - Channels that stop stalling do not clear the record.
- clear=1 in any state:
  - stall_sticky, first_ch, first_kind and trip_age go to 0; state goes to WATCH.
  - clear wins over a simultaneous trip.
  - If a block bit is still high, re-trip happens on the following edge.
- clear does not touch the stall counters or axis_block_sigs.
- Reset mid-count or in TRIPPED: every element returns to reset values on that edge, regardless of inputs.

Test Plan:
- NUM_CH=4, THRESHOLD=8; ch2 tvalid=1, tready=0 from edge 0 -> axis_block_sigs=4'b0100 visible after edge 7; stall_sticky=1 and first_ch=2, first_kind=1 after edge 8; trip_age=5 five cycles later.
- ch0 tready=1, tvalid=0 for 7 cycles, then one handshake, then 7 more stall cycles -> axis_block_sigs[0] never asserts; stall_sticky stays 0.
- ch1 both low, inst_idle=0 for 3 cycles between two 4-cycle stall runs -> counter holds; flag asserts on the 8th stall cycle. Repeat with inst_idle=1 -> no flag.
- ch3 and ch1 reach threshold on the same edge -> first_ch=1. Later trip of ch0 in TRIPPED -> first_ch still 1.
- With ch1 still blocked, pulse clear -> sticky 0 for one cycle, then re-trips with first_ch=1, trip_age restarts at 0. THRESHOLD=1: a single stall cycle flags immediately.
- CNT_W=4, THRESHOLD=15, stall for 40 cycles -> counter saturates at 15, no wrap, flag held. Assert reset at cycle 30 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/hls_axis_stall_detector.sv
// hls_axis_stall_detector
//   Watches the AXI-Stream handshakes of an HLS kernel instance and raises a
//   per-channel block flag for the deadlock monitor. A channel is blocked once
//   it has spent THRESHOLD consecutive cycles in a stalled handshake, where
//   backpressure is valid & !ready and starvation is ready & !valid. The first
//   trip is kept in a sticky record (channel, kind, age) until clear.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   tvalid[NUM_CH]   sampled AXIS TVALID per channel
//   tready[NUM_CH]   sampled AXIS TREADY per channel
//   inst_idle        kernel idle; resets counters of channels with both lines low
//   clear            one-cycle pulse, drops the sticky trip record
//   axis_block_sigs  registered per-channel stall flag
//   stall_sticky     set on the first trip, held until clear
//   first_ch         index of the lowest channel flagged at the trip
//   first_kind       1 = backpressure, 0 = starvation, at the trip
//   trip_age         saturating cycle count since the trip
module hls_axis_stall_detector #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1024,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] tvalid,
    input  logic [NUM_CH-1:0] tready,
    input  logic              inst_idle,
    input  logic              clear,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              stall_sticky,
    output logic [CH_W-1:0]   first_ch,
    output logic              first_kind,
    output logic [CNT_W-1:0]  trip_age
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

    typedef enum logic {WATCH, TRIPPED} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]  cnt_p1 [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] kind_p1;

    state_t            state_p2, state_nxt;
    logic              sticky_nxt;
    logic [CH_W-1:0]   ch_nxt;
    logic              kind_nxt;
    logic [CNT_W-1:0]  age_nxt;
    logic [CH_W-1:0]   low_idx;
    logic              low_kind;

    // Stage 1: per-channel stall counters, kind and block flags
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt_p1[i];
            if (tvalid[i] && tready[i])
                cnt_nxt[i] = '0;
            else if (tvalid[i] ^ tready[i])
                cnt_nxt[i] = sat_inc(cnt_p1[i]);
            else if (inst_idle)
                cnt_nxt[i] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
            kind_p1         <= '0;
            axis_block_sigs <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_p1[i]          <= cnt_nxt[i];
                // Flag is computed from the next count so that THRESHOLD=1
                // flags on the very edge that first samples the stall.
                axis_block_sigs[i] <= (cnt_nxt[i] >= THRESH_C);
                if (tvalid[i] ^ tready[i]) kind_p1[i] <= tvalid[i];
            end
        end
    end

    // Stage 2: trip record FSM driven by the registered block flags
    always_comb begin
        low_idx  = '0;
        low_kind = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) begin
                low_idx  = CH_W'(i);
                low_kind = kind_p1[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state_p2;
        sticky_nxt = stall_sticky;
        ch_nxt     = first_ch;
        kind_nxt   = first_kind;
        age_nxt    = trip_age;
        if (clear) begin
            // clear beats a same-cycle trip; a still-high flag re-trips next edge
            state_nxt  = WATCH;
            sticky_nxt = 1'b0;
            ch_nxt     = '0;
            kind_nxt   = 1'b0;
            age_nxt    = '0;
        end else begin
            case (state_p2)
                WATCH: begin
                    if (|axis_block_sigs) begin
                        state_nxt  = TRIPPED;
                        sticky_nxt = 1'b1;
                        ch_nxt     = low_idx;
                        kind_nxt   = low_kind;
                        age_nxt    = '0;
                    end
                end
                TRIPPED: age_nxt = sat_inc(trip_age);
                default: state_nxt = WATCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_p2     <= WATCH;
            stall_sticky <= 1'b0;
            first_ch     <= '0;
            first_kind   <= 1'b0;
            trip_age     <= '0;
        end else begin
            state_p2     <= state_nxt;
            stall_sticky <= sticky_nxt;
            first_ch     <= ch_nxt;
            first_kind   <= kind_nxt;
            trip_age     <= age_nxt;
        end
    end

endmodule

// File: tb/tb_hls_axis_stall_detector.sv
module tb_hls_axis_stall_detector;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;

    always #5 clock = ~clock;

    // Instance A: NUM_CH=4, CNT_W=16, THRESHOLD=8
    logic [3:0]  tvalid_a = '0, tready_a = '0;
    logic        idle_a = 1'b0;
    logic [3:0]  block_a;
    logic        sticky_a, kind_a;
    logic [1:0]  ch_a;
    logic [15:0] age_a;

    // Instance B: NUM_CH=1, THRESHOLD=1
    logic        tvalid_b = 1'b0, tready_b = 1'b0;
    logic        block_b, sticky_b, kind_b;
    logic [0:0]  ch_b;
    logic [15:0] age_b;

    // Instance C: NUM_CH=2, CNT_W=4, THRESHOLD=15
    logic [1:0]  tvalid_c = '0, tready_c = '0;
    logic [1:0]  block_c;
    logic        sticky_c, kind_c;
    logic [0:0]  ch_c;
    logic [3:0]  age_c;

    hls_axis_stall_detector #(.NUM_CH(4), .CNT_W(16), .THRESHOLD(8)) dut_a (
        .clock(clock), .reset(reset), .tvalid(tvalid_a), .tready(tready_a),
        .inst_idle(idle_a), .clear(clear), .axis_block_sigs(block_a),
        .stall_sticky(sticky_a), .first_ch(ch_a), .first_kind(kind_a),
        .trip_age(age_a)
    );

    hls_axis_stall_detector #(.NUM_CH(1), .CNT_W(16), .THRESHOLD(1)) dut_b (
        .clock(clock), .reset(reset), .tvalid(tvalid_b), .tready(tready_b),
        .inst_idle(1'b0), .clear(clear), .axis_block_sigs(block_b),
        .stall_sticky(sticky_b), .first_ch(ch_b), .first_kind(kind_b),
        .trip_age(age_b)
    );

    hls_axis_stall_detector #(.NUM_CH(2), .CNT_W(4), .THRESHOLD(15)) dut_c (
        .clock(clock), .reset(reset), .tvalid(tvalid_c), .tready(tready_c),
        .inst_idle(1'b0), .clear(clear), .axis_block_sigs(block_c),
        .stall_sticky(sticky_c), .first_ch(ch_c), .first_kind(kind_c),
        .trip_age(age_c)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        tvalid_a = '0; tready_a = '0; idle_a = 1'b0;
        tvalid_b = 1'b0; tready_b = 1'b0;
        tvalid_c = '0; tready_c = '0;
        clear = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_block", 32'(block_a), 32'h0);
        check("rst_sticky", 32'(sticky_a), 32'h0);
        check("rst_first_ch", 32'(ch_a), 32'h0);
        check("rst_age", 32'(age_a), 32'h0);

        // ch2 backpressure from edge 0
        tvalid_a = 4'b0100;
        tick(7);
        check("bp_block_e6", 32'(block_a), 32'h0);
        tick(1);
        check("bp_block_e7", 32'(block_a), 32'h4);
        check("bp_sticky_e7", 32'(sticky_a), 32'h0);
        tick(1);
        check("bp_sticky_e8", 32'(sticky_a), 32'h1);
        check("bp_first_ch", 32'(ch_a), 32'h2);
        check("bp_first_kind", 32'(kind_a), 32'h1);
        check("bp_age0", 32'(age_a), 32'h0);
        tick(5);
        check("bp_age5", 32'(age_a), 32'h5);

        // ch0 starvation broken by one handshake
        do_reset();
        tready_a = 4'b0001;
        tick(7);
        tvalid_a = 4'b0001;
        tick(1);
        tvalid_a = 4'b0000;
        tick(7);
        check("hs_block", 32'(block_a), 32'h0);
        tick(1);
        check("hs_sticky", 32'(sticky_a), 32'h0);

        // ch1: both-low hold with inst_idle=0, then continue as starvation
        do_reset();
        tvalid_a = 4'b0010;
        tick(4);
        tvalid_a = 4'b0000;
        tick(3);
        tready_a = 4'b0010;
        tick(3);
        check("hold_block7", 32'(block_a), 32'h0);
        tick(1);
        check("hold_block8", 32'(block_a), 32'h2);
        tick(1);
        check("hold_first_ch", 32'(ch_a), 32'h1);
        check("hold_first_kind", 32'(kind_a), 32'h0);

        // same with inst_idle=1: both-low resets the counter
        do_reset();
        idle_a = 1'b1;
        tvalid_a = 4'b0010;
        tick(4);
        tvalid_a = 4'b0000;
        tick(3);
        tvalid_a = 4'b0010;
        tick(4);
        check("idle_block4", 32'(block_a), 32'h0);
        tick(3);
        check("idle_block7", 32'(block_a), 32'h0);
        check("idle_sticky", 32'(sticky_a), 32'h0);

        // ch3 and ch1 trip together, lowest index wins
        do_reset();
        tvalid_a = 4'b1000;
        tready_a = 4'b0010;
        tick(8);
        check("dual_block", 32'(block_a), 32'ha);
        tick(1);
        check("dual_first_ch", 32'(ch_a), 32'h1);
        check("dual_first_kind", 32'(kind_a), 32'h0);
        // ch0: starvation then backpressure keeps counting, later trip ignored
        tready_a = 4'b0011;
        tick(4);
        tvalid_a = 4'b1001;
        tready_a = 4'b0010;
        tick(3);
        check("s2b_block7", 32'(block_a), 32'ha);
        tick(1);
        check("s2b_block8", 32'(block_a), 32'hb);
        tick(1);
        check("late_first_ch", 32'(ch_a), 32'h1);
        check("late_sticky", 32'(sticky_a), 32'h1);

        // clear while ch1 is still blocked; ch0/ch3 handshake away
        tvalid_a = 4'b1001;
        tready_a = 4'b1011;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_block", 32'(block_a), 32'h2);
        check("clr_sticky", 32'(sticky_a), 32'h0);
        check("clr_first_ch", 32'(ch_a), 32'h0);
        check("clr_age", 32'(age_a), 32'h0);
        tvalid_a = 4'b0000;
        tready_a = 4'b0010;
        tick(1);
        check("retrip_sticky", 32'(sticky_a), 32'h1);
        check("retrip_first_ch", 32'(ch_a), 32'h1);
        check("retrip_age0", 32'(age_a), 32'h0);
        tick(1);
        check("retrip_age1", 32'(age_a), 32'h1);

        // THRESHOLD=1 flags on the first stalled edge, drops on handshake
        do_reset();
        tvalid_b = 1'b1;
        tick(1);
        check("th1_block", 32'(block_b), 32'h1);
        tick(1);
        check("th1_sticky", 32'(sticky_b), 32'h1);
        check("th1_kind", 32'(kind_b), 32'h1);
        tready_b = 1'b1;
        tick(1);
        check("th1_drop", 32'(block_b), 32'h0);
        check("th1_sticky_held", 32'(sticky_b), 32'h1);

        // CNT_W=4, THRESHOLD=15: counter and trip_age saturate
        do_reset();
        tvalid_c = 2'b01;
        tick(14);
        check("sat_block14", 32'(block_c), 32'h0);
        tick(1);
        check("sat_block15", 32'(block_c), 32'h1);
        tick(25);
        check("sat_block40", 32'(block_c), 32'h1);
        check("sat_age", 32'(age_c), 32'hf);
        check("sat_first_ch", 32'(ch_c), 32'h0);

        // reset mid-TRIPPED while the stall is still driven
        do_reset();
        tvalid_c = 2'b01;
        tick(29);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_block", 32'(block_c), 32'h0);
        check("mid_rst_sticky", 32'(sticky_c), 32'h0);
        check("mid_rst_age", 32'(age_c), 32'h0);
        check("mid_rst_kind", 32'(kind_c), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
